// File: rtl/nibble_io_ports.sv
// nibble_io_ports
//   Board-side responder for the Nibbler core's I/O accesses. Holds the
//   three 4-bit output ports, synchronises and debounces the three 4-bit
//   pushbutton inputs and returns the debounced nibble on a read.
//
//   Optional feature macro: IO_EDGE_LATCH_EN
//     defined   -> sticky press bits st[2:0], read at io_addr=3 as {0, st},
//                  cleared by io_rd at io_addr=3 (a coincident press wins)
//     undefined -> no sticky logic, io_addr=3 reads 4'b0000, io_rd unused
//
//   Ports
//     clk            system clock, rising edge
//     reset          synchronous active-high reset
//     io_addr[1:0]   port select 0..2, 3 = status
//     io_wr          write strobe (one cycle = one write)
//     io_rd          read strobe (only side effect is the status clear)
//     wdata[3:0]     write data
//     rdata[3:0]     read data, combinational from io_addr
//     In0..In2[3:0]  raw asynchronous pushbutton inputs
//     Out0..Out2[3:0] registered output ports
module nibble_io_ports #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] io_addr,
   input  logic       io_wr,
   input  logic       io_rd,
   input  logic [3:0] wdata,
   output logic [3:0] rdata,
   input  logic [3:0] In0,
   input  logic [3:0] In1,
   input  logic [3:0] In2,
   output logic [3:0] Out0,
   output logic [3:0] Out1,
   output logic [3:0] Out2
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]              out0_q, out1_q, out2_q;
   logic [3:0]              out0_d, out1_d, out2_d;
   logic [11:0]             sync1_q, sync2_q;
   logic [11:0]             deb_q, deb_d;
   logic [11:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]              status_s;

   // Output port write decode; io_addr=3 writes are dropped
   always_comb begin
      out0_d = out0_q;
      out1_d = out1_q;
      out2_d = out2_q;
      if (io_wr) begin
         case (io_addr)
            2'd0:    out0_d = wdata;
            2'd1:    out1_d = wdata;
            2'd2:    out2_d = wdata;
            default: out0_d = out0_q;
         endcase
      end else begin
         out0_d = out0_q;
      end
   end

   // Per-bit debounce: the counter runs only while sync2 disagrees with deb
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 12; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            // accept point: counter returns to zero, so it can never wrap
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

`ifdef IO_EDGE_LATCH_EN
   logic [2:0] st_q, st_d;
   logic [2:0] rise_s;

   // Sticky press bits: clear on status read, a press in the same cycle wins
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rise_s[p] = |(deb_d[4*p +: 4] & ~deb_q[4*p +: 4]);
      end
      if (io_rd && (io_addr == 2'd3)) begin
         st_d = 3'b000;
      end else begin
         st_d = st_q;
      end
      st_d = st_d | rise_s;
   end

   // Sticky register
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q <= 3'b000;
      end else begin
         st_q <= st_d;
      end
   end

   assign status_s = {1'b0, st_q};
`else
   logic unused_rd_s;
   assign unused_rd_s = io_rd;
   assign status_s    = 4'b0000;
`endif

   // Read mux: returns the pre-write state, independent of io_rd
   always_comb begin
      case (io_addr)
         2'd0:    rdata = deb_q[3:0];
         2'd1:    rdata = deb_q[7:4];
         2'd2:    rdata = deb_q[11:8];
         default: rdata = status_s;
      endcase
   end

   // State registers: output ports, synchroniser, debounce state
   always_ff @(posedge clk) begin
      if (reset) begin
         out0_q  <= 4'b0000;
         out1_q  <= 4'b0000;
         out2_q  <= 4'b0000;
         sync1_q <= 12'h000;
         sync2_q <= 12'h000;
         deb_q   <= 12'h000;
         cnt_q   <= '0;
      end else begin
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
         sync1_q <= {In2, In1, In0};
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Out0 = out0_q;
   assign Out1 = out1_q;
   assign Out2 = out2_q;

endmodule
